// File: rtl/lisp_io_regs.sv
// lisp_io_regs: peripheral register bank on the lisp_core register bus.
// Console FIFO (index 0), LEDs (1), STATUS (4), GPIO channels (8+2n / 9+2n).
// Optional timer at indexes 2..3 when IO_TIMER_EN is defined.
module lisp_io_regs #(
  parameter int INDEX_WIDTH   = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int LED_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int GPIO_CHANNELS = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [INDEX_WIDTH-1:0]             register_index,
  input  logic                               register_read,
  input  logic                               register_write,
  input  logic [DATA_WIDTH-1:0]              register_write_value,
  output logic [DATA_WIDTH-1:0]              register_read_value,
  output logic                               console_valid,
  output logic [7:0]                         console_data,
  input  logic                               console_ready,
  output logic [LED_WIDTH-1:0]               leds,
  input  logic [GPIO_CHANNELS*DATA_WIDTH-1:0] gpio_in,
  output logic [GPIO_CHANNELS*DATA_WIDTH-1:0] gpio_out,
  output logic                               timer_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  overflow;

  logic [LED_WIDTH-1:0]  leds_r;
  logic [1:0]            status;
  logic [1:0]            status_clr;
  logic                  timer_match;

  logic [DATA_WIDTH-1:0] gpio_out_r [GPIO_CHANNELS];
  logic [DATA_WIDTH-1:0] gpio_s1    [GPIO_CHANNELS];
  logic [DATA_WIDTH-1:0] gpio_s2    [GPIO_CHANNELS];

  logic [DATA_WIDTH-1:0] rd_data;

  logic wr_idx0, wr_idx1, wr_idx4;

  assign wr_idx0 = register_write && (register_index == INDEX_WIDTH'(0));
  assign wr_idx1 = register_write && (register_index == INDEX_WIDTH'(1));
  assign wr_idx4 = register_write && (register_index == INDEX_WIDTH'(4));

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_idx0;
  assign pop      = console_valid && console_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign overflow = push && full && !pop;

  assign console_valid = !empty;
  assign console_data  = fifo_mem[rd_ptr];
  assign leds          = leds_r;
  assign timer_irq     = status[0];

  // Console FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= register_write_value[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // LED register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     leds_r <= '0;
    else if (wr_idx1) leds_r <= register_write_value[LED_WIDTH-1:0];
  end

`ifdef IO_TIMER_EN
  logic [DATA_WIDTH-1:0] timer_cnt;
  logic [DATA_WIDTH-1:0] timer_cmp;
  logic wr_idx2, wr_idx3;

  assign wr_idx2     = register_write && (register_index == INDEX_WIDTH'(2));
  assign wr_idx3     = register_write && (register_index == INDEX_WIDTH'(3));
  assign timer_match = (timer_cnt == timer_cmp);

  // Free-running timer with software restart and compare register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_cnt <= '0;
      timer_cmp <= '0;
    end else begin
      if (wr_idx2) timer_cnt <= '0;
      else         timer_cnt <= timer_cnt + 1'b1;
      if (wr_idx3) timer_cmp <= register_write_value;
    end
  end
`else
  assign timer_match = 1'b0;
`endif

  assign status_clr = wr_idx4 ? register_write_value[1:0] : 2'b00;

  // Sticky STATUS bits; a new event in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status <= '0;
    else          status <= (status & ~status_clr) | {overflow, timer_match};
  end

  // GPIO output registers and two-flop input synchronisers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < GPIO_CHANNELS; n++) begin
        gpio_out_r[n] <= '0;
        gpio_s1[n]    <= '0;
        gpio_s2[n]    <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < GPIO_CHANNELS; n++) begin
        if (register_write && (register_index == INDEX_WIDTH'(8 + 2 * n)))
          gpio_out_r[n] <= register_write_value;
        gpio_s1[n] <= gpio_in[n*DATA_WIDTH +: DATA_WIDTH];
        gpio_s2[n] <= gpio_s1[n];
      end
    end
  end

  // Flatten GPIO output channels onto the output bus.
  always_comb begin
    gpio_out = '0;
    for (int unsigned n = 0; n < GPIO_CHANNELS; n++)
      gpio_out[n*DATA_WIDTH +: DATA_WIDTH] = gpio_out_r[n];
  end

  // Read multiplexer; unmapped indexes return zero.
  always_comb begin
    rd_data = '0;
    case (register_index)
      INDEX_WIDTH'(0): begin
        rd_data[15]     = full;
        rd_data[14]     = empty;
        rd_data[CW-1:0] = count;
      end
      INDEX_WIDTH'(1): rd_data = DATA_WIDTH'(leds_r);
`ifdef IO_TIMER_EN
      INDEX_WIDTH'(2): rd_data = timer_cnt;
      INDEX_WIDTH'(3): rd_data = timer_cmp;
`endif
      INDEX_WIDTH'(4): rd_data = DATA_WIDTH'(status);
      default:         rd_data = '0;
    endcase
    for (int unsigned n = 0; n < GPIO_CHANNELS; n++) begin
      if (register_index == INDEX_WIDTH'(8 + 2 * n)) rd_data = gpio_out_r[n];
      if (register_index == INDEX_WIDTH'(9 + 2 * n)) rd_data = gpio_s2[n];
    end
  end

  // Registered read data, captured only on a read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           register_read_value <= '0;
    else if (register_read) register_read_value <= rd_data;
  end

endmodule

// File: tb/tb_lisp_io_regs.sv
// tb_lisp_io_regs: directed self-checking bench for lisp_io_regs (default params).
module tb_lisp_io_regs;

  logic        clk;
  logic        reset_n;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic [7:0]  leds;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int checks;
  int failures;
  logic [15:0] rv;

  lisp_io_regs #(
    .INDEX_WIDTH(7), .DATA_WIDTH(16), .LED_WIDTH(8), .FIFO_DEPTH(8), .GPIO_CHANNELS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value),
    .console_valid(console_valid), .console_data(console_data),
    .console_ready(console_ready), .leds(leds),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic bus_write(input logic [6:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index = idx; register_write_value = val; register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] idx, output logic [15:0] val);
    @(negedge clk);
    register_index = idx; register_read = 1'b1;
    @(negedge clk);
    register_read = 1'b0;
    val = register_read_value;
  endtask

  task automatic test_reset();
    bus_write(7'd1, 16'h00C3);
    bus_write(7'd8, 16'hABCD);
    bus_write(7'd0, 16'h0041);
    bus_read(7'd1, rv);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=00", leds); end
    checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
    checks++; if (console_valid !== 1'b0 || console_data !== 8'h00) begin failures++;
      $display("FAIL reset_console got=%b/%h exp=0/00", console_valid, console_data); end
    checks++; if (register_read_value !== 16'h0) begin failures++; $display("FAIL reset_rdval got=%h exp=0000", register_read_value); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    @(negedge clk); reset_n = 1'b1;
    bus_read(7'd0, rv);
    checks++; if (rv !== 16'h4000) begin failures++; $display("FAIL reset_idx0 got=%h exp=4000", rv); end
  endtask

  task automatic test_fifo();
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(7'd0, 16'(8'h41 + i));
    bus_read(7'd0, rv);
    checks++; if (rv !== 16'h8008) begin failures++; $display("FAIL fifo_full_idx0 got=%h exp=8008", rv); end
    bus_write(7'd0, 16'h0049);
    bus_read(7'd4, rv);
    checks++; if (rv !== 16'h0002) begin failures++; $display("FAIL fifo_overflow_status got=%h exp=0002", rv); end
    bus_read(7'd0, rv);
    checks++; if (rv !== 16'h8008) begin failures++; $display("FAIL fifo_after_ovf_idx0 got=%h exp=8008", rv); end
    checks++; if (console_data !== 8'h41) begin failures++; $display("FAIL fifo_head_stable got=%h exp=41", console_data); end
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (console_valid !== 1'b1 || console_data !== 8'(8'h41 + i)) begin failures++;
        $display("FAIL fifo_stream%0d got=%b/%h exp=1/%h", i, console_valid, console_data, 8'(8'h41 + i)); end
      @(negedge clk);
    end
    console_ready = 1'b0;
    checks++; if (console_valid !== 1'b0) begin failures++; $display("FAIL fifo_drained got=%b exp=0", console_valid); end
    bus_write(7'd4, 16'h0002);
    bus_read(7'd4, rv);
    checks++; if (rv !== 16'h0000) begin failures++; $display("FAIL status_w1c got=%h exp=0000", rv); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [8];
    for (int i = 0; i < 7; i++) exp_q[i] = 8'(8'h31 + i);
    exp_q[7] = 8'h5A;
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(7'd0, 16'(8'h30 + i));
    console_ready = 1'b1;
    register_index = 7'd0; register_write_value = 16'h005A; register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0; console_ready = 1'b0;
    bus_read(7'd0, rv);
    checks++; if (rv !== 16'h8008) begin failures++; $display("FAIL pushpop_count got=%h exp=8008", rv); end
    bus_read(7'd4, rv);
    checks++; if (rv !== 16'h0000) begin failures++; $display("FAIL pushpop_no_ovf got=%h exp=0000", rv); end
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (console_valid !== 1'b1 || console_data !== exp_q[i]) begin failures++;
        $display("FAIL pushpop_stream%0d got=%b/%h exp=1/%h", i, console_valid, console_data, exp_q[i]); end
      @(negedge clk);
    end
    console_ready = 1'b0;
    checks++; if (console_valid !== 1'b0) begin failures++; $display("FAIL pushpop_drained got=%b exp=0", console_valid); end
  endtask

  task automatic test_regs();
    bus_write(7'd1, 16'h00A5);
    checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds got=%h exp=a5", leds); end
    bus_read(7'd1, rv);
    checks++; if (rv !== 16'h00A5) begin failures++; $display("FAIL leds_read got=%h exp=00a5", rv); end
    bus_write(7'd8, 16'h1234);
    checks++; if (gpio_out !== 32'h0000_1234) begin failures++; $display("FAIL gpio_out0 got=%h exp=00001234", gpio_out); end
    bus_write(7'd10, 16'h5678);
    checks++; if (gpio_out !== 32'h5678_1234) begin failures++; $display("FAIL gpio_out1 got=%h exp=56781234", gpio_out); end
    gpio_in = 32'hBEEF_0000;
    repeat (3) @(negedge clk);
    bus_read(7'd11, rv);
    checks++; if (rv !== 16'hBEEF) begin failures++; $display("FAIL gpio_in1 got=%h exp=beef", rv); end
    bus_read(7'd9, rv);
    checks++; if (rv !== 16'h0000) begin failures++; $display("FAIL gpio_in0 got=%h exp=0000", rv); end
    bus_write(7'd40, 16'hFFFF);
    bus_read(7'd40, rv);
    checks++; if (rv !== 16'h0000) begin failures++; $display("FAIL unmapped got=%h exp=0000", rv); end
    checks++; if (leds !== 8'hA5 || gpio_out !== 32'h5678_1234) begin failures++;
      $display("FAIL unmapped_write got=%h/%h exp=a5/56781234", leds, gpio_out); end
  endtask

  task automatic test_timer();
`ifdef IO_TIMER_EN
    int k;
    bus_write(7'd3, 16'd100);
    bus_write(7'd2, 16'h0000);
    k = 0;
    bus_write(7'd4, 16'h0001);
    k = 2;
    while (timer_irq !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k < 100 || k > 101) begin failures++; $display("FAIL timer_delay got=%0d exp=100..101", k); end
    bus_write(7'd4, 16'h0001);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_clear got=%b exp=0", timer_irq); end
`else
    bus_write(7'd3, 16'd5);
    bus_read(7'd2, rv);
    checks++; if (rv !== 16'h0000) begin failures++; $display("FAIL notimer_idx2 got=%h exp=0000", rv); end
    bus_read(7'd3, rv);
    checks++; if (rv !== 16'h0000) begin failures++; $display("FAIL notimer_idx3 got=%h exp=0000", rv); end
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (timer_irq !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL notimer_irq got=1 exp=0"); end
    end
`endif
  endtask

  task automatic test_read_latency();
    bus_write(7'd1, 16'h003C);
    bus_read(7'd40, rv);
    @(negedge clk);
    register_index = 7'd1; register_read = 1'b1;
    #4;
    checks++; if (register_read_value !== 16'h0000) begin failures++; $display("FAIL lat_before_edge got=%h exp=0000", register_read_value); end
    @(posedge clk); #1;
    checks++; if (register_read_value !== 16'h003C) begin failures++; $display("FAIL lat_after_edge got=%h exp=003c", register_read_value); end
    register_read = 1'b0;
    bus_write(7'd1, 16'h0055);
    repeat (2) @(negedge clk);
    checks++; if (register_read_value !== 16'h003C) begin failures++; $display("FAIL lat_hold got=%h exp=003c", register_read_value); end
    @(negedge clk);
    register_index = 7'd1; register_read = 1'b1; register_write = 1'b1; register_write_value = 16'h0077;
    @(negedge clk);
    register_read = 1'b0; register_write = 1'b0;
    checks++; if (register_read_value !== 16'h0055) begin failures++; $display("FAIL rd_wr_same got=%h exp=0055", register_read_value); end
    bus_read(7'd1, rv);
    checks++; if (rv !== 16'h0077) begin failures++; $display("FAIL rd_after_wr got=%h exp=0077", rv); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    register_index = '0; register_read = 1'b0; register_write = 1'b0;
    register_write_value = '0; console_ready = 1'b0; gpio_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fifo();
    test_full_push_pop();
    test_regs();
    test_timer();
    test_read_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
